// File: rtl/knight_rider_pkg.sv
// knight_rider_pkg: shared defaults and brightness arithmetic for the Knight Rider LED trail.
//   N_LEDS_DEF / PWM_BITS_DEF / DECAY_STEP_DEF : default channel count, PWM resolution, fade step
//   PWM_MAX                                    : full-scale brightness for the default resolution
//   sat_sub                                    : unsigned subtract clamped at zero
package knight_rider_pkg;
    localparam int N_LEDS_DEF     = 8;
    localparam int PWM_BITS_DEF   = 4;
    localparam int PWM_MAX        = (1 << PWM_BITS_DEF) - 1;
    localparam int DECAY_STEP_DEF = 4;

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned s);
        return (a > s) ? a - s : 0;
    endfunction
endpackage

// File: rtl/trail_cell.sv
// trail_cell: one LED channel -- brightness register with load/clear/decay priority and PWM compare.
//   clk, reset(active-low sync) : clock and reset
//   led_in                      : scanner position bit for this channel (load to full brightness)
//   decay_tick, fade_en         : fade strobe and trail-mode enable
//   pwm_cnt                     : shared free-running PWM counter
//   pwm_on                      : unregistered compare result (top registers it)
//   lit                         : brightness is nonzero
module trail_cell
    import knight_rider_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int MAX_B      = PWM_MAX,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                led_in,
    input  logic                decay_tick,
    input  logic                fade_en,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_on,
    output logic                lit
);
    localparam logic [PWM_BITS-1:0] BMAX = PWM_BITS'(MAX_B);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

    logic [PWM_BITS-1:0] b;

    always_ff @(posedge clk)
        if (!reset) b <= '0;
        else        b <= led_in     ? BMAX :
                         !fade_en   ? '0   :
                         decay_tick ? PWM_BITS'(sat_sub(32'(b), 32'(STEP))) : b;

    // Full scale must stay lit even when pwm_cnt reaches PWM_MAX, hence the explicit equality term.
    assign pwm_on = (b == BMAX) | (b > pwm_cnt);
    assign lit    = |b;
endmodule

// File: rtl/knight_rider_trail.sv
// knight_rider_trail: PWM LED driver that leaves a fading comet tail behind the scanner position.
//   clk, reset(active-low sync) : clock and reset
//   leds_in                     : scanner position vector (any number of bits may be set)
//   decay_tick                  : one-cycle strobe advancing the fade by one step
//   fade_en                     : 1 = trail mode, 0 = plain mirror of leds_in
//   leds_pwm                    : registered PWM drive
//   trail_active                : registered, any channel brightness nonzero
module knight_rider_trail
    import knight_rider_pkg::*;
#(
    parameter int N_LEDS     = N_LEDS_DEF,
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_LEDS-1:0] leds_in,
    input  logic              decay_tick,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] leds_pwm,
    output logic              trail_active
);
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LEDS-1:0]   pwm_on;
    logic [N_LEDS-1:0]   lit;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_cell
        trail_cell #(
            .PWM_BITS  (PWM_BITS),
            .MAX_B     ((1 << PWM_BITS) - 1),
            .DECAY_STEP(DECAY_STEP)
        ) u_cell (
            .clk       (clk),
            .reset     (reset),
            .led_in    (leds_in[i]),
            .decay_tick(decay_tick),
            .fade_en   (fade_en),
            .pwm_cnt   (pwm_cnt),
            .pwm_on    (pwm_on[i]),
            .lit       (lit[i])
        );
    end

    always_ff @(posedge clk)
        if (!reset) begin
            pwm_cnt      <= '0;
            leds_pwm     <= '0;
            trail_active <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            leds_pwm     <= pwm_on;
            trail_active <= |lit;
        end
endmodule

// File: tb/tb_knight_rider_trail.sv
// tb_knight_rider_trail: scoreboard-driven checks of reset, decay, duty, load priority, mode switch and mid-fade reset.
module tb_knight_rider_trail;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] leds_in = '0;
    logic       decay_tick = 1'b0;
    logic       fade_en = 1'b1;
    logic [7:0] leds_pwm;
    logic       trail_active;

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];
    int e;
    int got;

    logic [3:0] bq [8];

    knight_rider_trail dut (
        .clk         (clk),
        .reset       (reset),
        .leds_in     (leds_in),
        .decay_tick  (decay_tick),
        .fade_en     (fade_en),
        .leds_pwm    (leds_pwm),
        .trail_active(trail_active)
    );

    for (genvar g = 0; g < 8; g++) begin : g_b
        assign bq[g] = dut.g_cell[g].u_cell.b;
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            leds_in    = 8'($urandom);
            decay_tick = 1'($urandom);
            fade_en    = 1'($urandom);
            exp_q.push_back(0);
            exp_q.push_back(0);
            exp_q.push_back(0);
            tick();
            e = exp_q.pop_front(); got = int'(leds_pwm); vectors++;
            if (got !== e) begin errors++; $display("FAIL reset_leds_pwm got=%0h want=%0h", got, e); end
            e = exp_q.pop_front(); got = int'(trail_active); vectors++;
            if (got !== e) begin errors++; $display("FAIL reset_trail_active got=%0d want=%0d", got, e); end
            e = exp_q.pop_front(); got = int'(dut.pwm_cnt); vectors++;
            if (got !== e) begin errors++; $display("FAIL reset_pwm_cnt got=%0d want=%0d", got, e); end
        end
        leds_in = '0; decay_tick = 1'b0; fade_en = 1'b1; reset = 1'b1;
        exp_q.push_back(1);
        tick();
        e = exp_q.pop_front(); got = int'(dut.pwm_cnt); vectors++;
        if (got !== e) begin errors++; $display("FAIL release_pwm_cnt got=%0d want=%0d", got, e); end
    endtask

    task automatic test_decay();
        int seq[4] = '{11, 7, 3, 0};
        fade_en = 1'b1; leds_in = 8'h01;
        exp_q.push_back(15);
        tick();
        leds_in = 8'h00;
        e = exp_q.pop_front(); got = int'(bq[0]); vectors++;
        if (got !== e) begin errors++; $display("FAIL decay_load got=%0d want=%0d", got, e); end
        for (int s = 0; s < 4; s++) begin
            repeat (15) tick();
            decay_tick = 1'b1;
            exp_q.push_back(seq[s]);
            tick();
            decay_tick = 1'b0;
            e = exp_q.pop_front(); got = int'(bq[0]); vectors++;
            if (got !== e) begin errors++; $display("FAIL decay_step%0d got=%0d want=%0d", s, got, e); end
            if (s == 3) begin
                vectors++;
                if (trail_active !== 1'b1) begin errors++; $display("FAIL trail_lag got=%0d want=1", trail_active); end
            end
        end
        exp_q.push_back(0);
        tick();
        e = exp_q.pop_front(); got = int'(trail_active); vectors++;
        if (got !== e) begin errors++; $display("FAIL trail_drop got=%0d want=%0d", got, e); end
        decay_tick = 1'b1;
        exp_q.push_back(0);
        tick();
        decay_tick = 1'b0;
        e = exp_q.pop_front(); got = int'(bq[0]); vectors++;
        if (got !== e) begin errors++; $display("FAIL decay_nowrap got=%0d want=%0d", got, e); end
    endtask

    task automatic test_duty();
        int cnt;
        leds_in = 8'h01; fade_en = 1'b1; tick();
        leds_in = 8'h00; decay_tick = 1'b1; tick();
        decay_tick = 1'b0; tick();
        exp_q.push_back(11);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin tick(); cnt += int'(leds_pwm[0]); end
        e = exp_q.pop_front(); vectors++;
        if (cnt !== e) begin errors++; $display("FAIL duty_11 got=%0d want=%0d", cnt, e); end
        leds_in = 8'h01; tick();
        leds_in = 8'h00; tick();
        exp_q.push_back(16);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin tick(); cnt += int'(leds_pwm[0]); end
        e = exp_q.pop_front(); vectors++;
        if (cnt !== e) begin errors++; $display("FAIL duty_15 got=%0d want=%0d", cnt, e); end
        fade_en = 1'b0; tick(); tick();
        fade_en = 1'b1;
        exp_q.push_back(0);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin tick(); cnt += int'(leds_pwm[0]); end
        e = exp_q.pop_front(); vectors++;
        if (cnt !== e) begin errors++; $display("FAIL duty_0 got=%0d want=%0d", cnt, e); end
    endtask

    task automatic test_load_wins();
        leds_in = 8'h08; tick();
        leds_in = 8'h00; decay_tick = 1'b1; tick(); tick();
        decay_tick = 1'b0;
        exp_q.push_back(7);
        e = exp_q.pop_front(); got = int'(bq[3]); vectors++;
        if (got !== e) begin errors++; $display("FAIL load_pre got=%0d want=%0d", got, e); end
        leds_in = 8'h08; decay_tick = 1'b1;
        exp_q.push_back(15);
        tick();
        leds_in = 8'h00; decay_tick = 1'b0;
        e = exp_q.pop_front(); got = int'(bq[3]); vectors++;
        if (got !== e) begin errors++; $display("FAIL load_wins got=%0d want=%0d", got, e); end
    endtask

    task automatic test_mode_switch();
        fade_en = 1'b1; leds_in = 8'h01; tick();
        leds_in = 8'h00; decay_tick = 1'b1; tick(); tick();
        decay_tick = 1'b0;
        vectors++;
        if (bq[0] !== 4'd7) begin errors++; $display("FAIL mode_pre got=%0d want=7", bq[0]); end
        fade_en = 1'b0; leds_in = 8'h10;
        exp_q.push_back(0);
        exp_q.push_back(15);
        exp_q.push_back(8'h10);
        tick();
        leds_in = 8'h00;
        e = exp_q.pop_front(); got = int'(bq[0]); vectors++;
        if (got !== e) begin errors++; $display("FAIL mode_b0 got=%0d want=%0d", got, e); end
        e = exp_q.pop_front(); got = int'(bq[4]); vectors++;
        if (got !== e) begin errors++; $display("FAIL mode_b4 got=%0d want=%0d", got, e); end
        tick();
        e = exp_q.pop_front(); got = int'(leds_pwm); vectors++;
        if (got !== e) begin errors++; $display("FAIL mode_pwm got=%0h want=%0h", got, e); end
        fade_en = 1'b1;
    endtask

    task automatic test_mid_reset();
        fade_en = 1'b1; leds_in = 8'h04; tick();
        leds_in = 8'h02; decay_tick = 1'b1; tick();
        leds_in = 8'h01; tick();
        leds_in = 8'h00; decay_tick = 1'b0;
        exp_q.push_back({20'd0, 4'd7, 4'd11, 4'd15});
        e = exp_q.pop_front(); got = {20'd0, bq[2], bq[1], bq[0]}; vectors++;
        if (got !== e) begin errors++; $display("FAIL tail_pre got=%0h want=%0h", got, e); end
        reset = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(0);
        tick();
        reset = 1'b1;
        e = exp_q.pop_front(); got = int'({bq[7], bq[6], bq[5], bq[4], bq[3], bq[2], bq[1], bq[0]}); vectors++;
        if (got !== e) begin errors++; $display("FAIL reset_b got=%0h want=%0h", got, e); end
        e = exp_q.pop_front(); got = int'(leds_pwm); vectors++;
        if (got !== e) begin errors++; $display("FAIL reset_pwm got=%0h want=%0h", got, e); end
        exp_q.push_back(0);
        exp_q.push_back(0);
        tick();
        e = exp_q.pop_front(); got = int'(leds_pwm); vectors++;
        if (got !== e) begin errors++; $display("FAIL post_reset_pwm got=%0h want=%0h", got, e); end
        e = exp_q.pop_front(); got = int'(trail_active); vectors++;
        if (got !== e) begin errors++; $display("FAIL post_reset_active got=%0d want=%0d", got, e); end
    endtask

    initial begin
        test_reset();
        test_decay();
        test_duty();
        test_load_wins();
        test_mode_switch();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
